// File: rtl/wb_inputs.sv
// Wishbone B4 pipelined slave exposing synchronized, debounced board inputs with sticky edge flags.
// Optional feature: define WB_INPUTS_IRQ_EN to add the IEN register and a registered level interrupt.
module wb_inputs #(
    parameter int NUM_IN  = 8,
    parameter int DEB_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [31:0]       wb_adr,
    input  logic [3:0]        wb_sel,
    input  logic [31:0]       wb_dat_m,
    output logic [31:0]       wb_dat_s,
    output logic              wb_ack,
    output logic              wb_stall,
    input  logic [NUM_IN-1:0] in,
    output logic              irq
);

    localparam int CW = $clog2(DEB_CYC);

    logic [NUM_IN-1:0] s1_r;
    logic [NUM_IN-1:0] s2_r;
    logic [NUM_IN-1:0] stable_r;
    logic [NUM_IN-1:0] stable_nxt_s;
    logic [CW-1:0]     cnt_r      [NUM_IN];
    logic [CW-1:0]     cnt_nxt_s  [NUM_IN];
    logic [1:0]        init_r;
    logic [NUM_IN-1:0] rise_r;
    logic [NUM_IN-1:0] fall_r;
    logic [NUM_IN-1:0] rise_set_s;
    logic [NUM_IN-1:0] fall_set_s;
    logic [NUM_IN-1:0] clr_rise_s;
    logic [NUM_IN-1:0] clr_fall_s;
    logic              acc_s;
    logic              wr_s;
    logic [2:0]        off_s;
    logic [31:0]       rd_s;
    logic              unused_s;

    assign wb_stall = 1'b0;
    assign acc_s    = wb_cyc & wb_stb;
    assign wr_s     = acc_s & wb_we;
    assign off_s    = wb_adr[4:2];
    assign unused_s = ^{wb_sel, wb_adr[31:5], wb_adr[1:0], wb_dat_m};

    // Two-flop synchronizer for the asynchronous inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r <= in;
            s2_r <= s1_r;
        end
    end

    // Init window counter: saturates at 3 once the synchronizer holds valid data
    always_ff @(posedge clk) begin
        if (rst) begin
            init_r <= 2'd0;
        end else if (init_r != 2'd3) begin
            init_r <= init_r + 2'd1;
        end else begin
            init_r <= init_r;
        end
    end

    // Per-bit debounce next state; the last init cycle adopts the synchronized level silently
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < NUM_IN; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (init_r != 2'd3) begin
                cnt_nxt_s[i] = '0;
                if (init_r == 2'd2) begin
                    stable_nxt_s[i] = s2_r[i];
                end else begin
                    stable_nxt_s[i] = stable_r[i];
                end
            end else if (s2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == CW'(DEB_CYC - 1)) begin
                stable_nxt_s[i] = s2_r[i];
                cnt_nxt_s[i]    = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
        rise_set_s = (init_r == 2'd3) ? (stable_nxt_s & ~stable_r) : '0;
        fall_set_s = (init_r == 2'd3) ? (~stable_nxt_s & stable_r) : '0;
    end

    // Debounce state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_r <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            stable_r <= stable_nxt_s;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign clr_rise_s = (wr_s && (off_s == 3'd2)) ? wb_dat_m[NUM_IN-1:0] : '0;
    assign clr_fall_s = (wr_s && (off_s == 3'd3)) ? wb_dat_m[NUM_IN-1:0] : '0;

    // Sticky edge flags; a new edge overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_r <= '0;
            fall_r <= '0;
        end else begin
            rise_r <= (rise_r & ~clr_rise_s) | rise_set_s;
            fall_r <= (fall_r & ~clr_fall_s) | fall_set_s;
        end
    end

`ifdef WB_INPUTS_IRQ_EN
    logic [NUM_IN-1:0] ien_r;
    logic              irq_r;

    // Interrupt enable register and registered interrupt level
    always_ff @(posedge clk) begin
        if (rst) begin
            ien_r <= '0;
            irq_r <= 1'b0;
        end else begin
            if (wr_s && (off_s == 3'd4)) begin
                ien_r <= wb_dat_m[NUM_IN-1:0];
            end else begin
                ien_r <= ien_r;
            end
            irq_r <= |((rise_r | fall_r) & ien_r);
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    // Read data mux; unused upper bits stay zero
    always_comb begin
        rd_s = 32'd0;
        case (off_s)
            3'd0:    rd_s[NUM_IN-1:0] = stable_r;
            3'd1:    rd_s[NUM_IN-1:0] = s2_r;
            3'd2:    rd_s[NUM_IN-1:0] = rise_r;
            3'd3:    rd_s[NUM_IN-1:0] = fall_r;
`ifdef WB_INPUTS_IRQ_EN
            3'd4:    rd_s[NUM_IN-1:0] = ien_r;
`endif
            default: rd_s = 32'd0;
        endcase
    end

    // Single-cycle ack; data bus is zero outside read acks
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_dat_s <= 32'd0;
        end else begin
            wb_ack   <= acc_s;
            wb_dat_s <= (acc_s && !wb_we) ? rd_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_inputs.sv
// Randomized scoreboard bench for wb_inputs (NUM_IN=8, DEB_CYC=4); honours WB_INPUTS_IRQ_EN.
module tb_wb_inputs;
    localparam int NUM_IN  = 8;
    localparam int DEB_CYC = 4;
`ifdef WB_INPUTS_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0, dat_m = 32'd0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_s;
    logic        ack, stall, irq;
    logic [7:0]  in = 8'h05;

    wb_inputs #(.NUM_IN(NUM_IN), .DEB_CYC(DEB_CYC)) dut (
        .clk(clk), .rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
        .wb_adr(adr), .wb_sel(sel), .wb_dat_m(dat_m), .wb_dat_s(dat_s),
        .wb_ack(ack), .wb_stall(stall), .in(in), .irq(irq)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic        ack_exp = 1'b0;
    logic        irq_exp = 1'b0;
    logic [32:0] sbq[$];

    // Reference model: an input level is accepted once the synchronized value has
    // been different from the accepted level for DEB_CYC consecutive cycles.
    initial begin : model
        int n;
        int since [NUM_IN];
        int init_left;
        logic [7:0]  st, rise, fall, ien, s1, s2, s2p, last, sr, sf, cr, cf;
        logic [31:0] rd;
        n = 0; st = '0; rise = '0; fall = '0; ien = '0; s1 = '0; s2 = '0; last = '0;
        init_left = 3;
        forever begin
            @(posedge clk);
            n++;
            if (rst) begin
                st = '0; rise = '0; fall = '0; ien = '0; s1 = '0; s2 = '0; last = '0;
                for (int i = 0; i < NUM_IN; i++) since[i] = n;
                init_left = 3;
                ack_exp = 1'b0;
                irq_exp = 1'b0;
            end else begin
                s2p = s2;
                for (int i = 0; i < NUM_IN; i++) if (s2p[i] != last[i]) since[i] = n;
                last = s2p;
                irq_exp = IRQ_BUILD ? |((rise | fall) & ien) : 1'b0;
                ack_exp = cyc & stb;
                cr = '0; cf = '0;
                if (cyc && stb) begin
                    case (adr[4:2])
                        3'd0:    rd = {24'd0, st};
                        3'd1:    rd = {24'd0, s2p};
                        3'd2:    rd = {24'd0, rise};
                        3'd3:    rd = {24'd0, fall};
                        3'd4:    rd = {24'd0, ien};
                        default: rd = 32'd0;
                    endcase
                    sbq.push_back({!we, rd});
                    if (we && adr[4:2] == 3'd2) cr = dat_m[7:0];
                    if (we && adr[4:2] == 3'd3) cf = dat_m[7:0];
                    if (we && adr[4:2] == 3'd4 && IRQ_BUILD) ien = dat_m[7:0];
                end
                sr = '0; sf = '0;
                if (init_left > 0) begin
                    init_left--;
                    if (init_left == 0) st = s2p;
                end else begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (s2p[i] != st[i] && (n - since[i] + 1) >= DEB_CYC) begin
                            if (s2p[i]) sr[i] = 1'b1;
                            else        sf[i] = 1'b1;
                            st[i] = s2p[i];
                        end
                    end
                end
                rise = (rise & ~cr) | sr;
                fall = (fall & ~cf) | sf;
                s2 = s1;
                s1 = in;
            end
        end
    end

    // Monitor: checks handshake, interrupt and read data against the scoreboard
    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_vec++;
                if (ack !== ack_exp) begin
                    n_err++;
                    $display("FAIL ack: got %b want %b at %0t", ack, ack_exp, $time);
                end
                n_vec++;
                if (irq !== irq_exp) begin
                    n_err++;
                    $display("FAIL irq: got %b want %b at %0t", irq, irq_exp, $time);
                end
                if (ack_exp) begin
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL scoreboard: empty on ack at %0t", $time);
                    end else begin
                        e = sbq.pop_front();
                        if (e[32]) begin
                            n_vec++;
                            if (dat_s !== e[31:0]) begin
                                n_err++;
                                $display("FAIL rdata: got %h want %h at %0t", dat_s, e[31:0], $time);
                            end
                        end
                    end
                end else begin
                    n_vec++;
                    if (dat_s !== 32'd0 || stall !== 1'b0) begin
                        n_err++;
                        $display("FAIL idle_bus: dat_s %h stall %b want 0 at %0t", dat_s, stall, $time);
                    end
                end
            end
        end
    end

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_m = d;
    endtask

    task automatic idle();
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus(1'b0, a, 32'd0);
        idle();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
        idle();
    endtask

    task automatic set_in(input logic [7:0] v);
        @(negedge clk);
        in = v;
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin : stim
        logic [31:0] r;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // inputs high at reset become DATA without any RISE
        wait_cyc(10);
        rd(32'h00); rd(32'h08); rd(32'h0C);

        // settle to zero, clear flags, then a clean rise on bit0
        set_in(8'h00);
        wait_cyc(10);
        wr(32'h0C, 32'hFF);
        set_in(8'h01);
        for (int k = 0; k < 8; k++) bus(1'b0, 32'h00, 32'd0);
        idle();
        rd(32'h08); wr(32'h08, 32'h01); rd(32'h08);

        // three-cycle glitch on bit1 is rejected
        set_in(8'h03);
        wait_cyc(2);
        set_in(8'h01);
        wait_cyc(10);
        rd(32'h00); rd(32'h08); rd(32'h0C);

        // FALL bit2 set, then clear it in the same cycle a new fall is captured
        set_in(8'h05); wait_cyc(10);
        set_in(8'h01); wait_cyc(10);
        set_in(8'h05); wait_cyc(10);
        @(negedge clk);
        in = 8'h01;
        repeat (5) @(posedge clk);
        bus(1'b1, 32'h0C, 32'h04);
        idle();
        rd(32'h0C);

        // back-to-back pipelined reads
        bus(1'b0, 32'h00, 32'd0);
        bus(1'b0, 32'h04, 32'd0);
        bus(1'b0, 32'h14, 32'd0);
        idle();

        // interrupt on enabled bit7
        wr(32'h08, 32'hFF); wr(32'h0C, 32'hFF);
        wr(32'h10, 32'h80);
        rd(32'h10);
        set_in(8'h81);
        wait_cyc(10);
        wr(32'h08, 32'h80);
        wait_cyc(3);

        // reset in the middle of a debounce window
        set_in(8'h7E);
        wait_cyc(3);
        @(negedge clk) rst = 1'b1;
        wait_cyc(2);
        @(negedge clk) rst = 1'b0;
        wait_cyc(10);
        rd(32'h00); rd(32'h08); rd(32'h0C);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 4))
                0: set_in(8'($urandom));
                1: begin
                    r = $urandom;
                    rd({27'd0, 3'($urandom_range(0, 7)), r[1:0]});
                end
                2: begin
                    r = $urandom;
                    wr({27'd0, 3'($urandom_range(2, 4)), 2'b00}, r);
                end
                3: begin
                    bus(1'b0, {27'd0, 3'($urandom_range(0, 5)), 2'b00}, 32'd0);
                    bus(1'b0, {27'd0, 3'($urandom_range(0, 5)), 2'b00}, 32'd0);
                    idle();
                end
                default: wait_cyc($urandom_range(0, 6));
            endcase
        end

        idle();
        wait_cyc(10);
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
